// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the fetch sequencer and its next-PC select.
package pc_fetch_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int INST_STEP = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        RESP   = 3'd2,
        HOLD   = 3'd3,
        HALTED = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_ctrl_target_sel.sv
// Priority select of the next PC from an execute-stage resolve:
// JumpReg > Cnd|Jump > Halt. Purely combinational.
module pc_target_sel
    import pc_fetch_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            resolveValid,
    input  logic            JumpReg,
    input  logic            Cnd,
    input  logic            Jump,
    input  logic            Halt,
    input  logic [XLEN-1:0] resolvePC,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] aluResult,
    output logic            redirect,
    output logic            halt,
    output logic [XLEN-1:0] target,
    output logic [XLEN-1:0] halt_pc
);

    localparam logic [XLEN-1:0] BIT0_MASK = ~XLEN'(1);

    always_comb begin
        redirect = resolveValid && (JumpReg || Cnd || Jump);
        halt     = resolveValid && Halt && !(JumpReg || Cnd || Jump);
        target   = JumpReg ? (aluResult & BIT0_MASK) : (resolvePC + imm);
        halt_pc  = resolvePC + XLEN'(INST_STEP);
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, runs the imem request/response handshake and
// presents instructions to decode. Optional feature macro: MISALIGN_TRAP_EN.
module pc_fetch_ctrl
    import pc_fetch_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imemReq,
    output logic [XLEN-1:0] imemAddr,
    input  logic            imemReady,
    input  logic            imemValid,
    input  logic [31:0]     imemRdata,
    output logic            instValid,
    input  logic            instReady,
    output logic [31:0]     instOut,
    output logic [XLEN-1:0] instPC,
    input  logic            resolveValid,
    input  logic [XLEN-1:0] resolvePC,
    input  logic            Cnd,
    input  logic            Jump,
    input  logic            JumpReg,
    input  logic            Halt,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] aluResult,
    output logic            halted,
    input  logic            resume,
`ifdef MISALIGN_TRAP_EN
    output logic            trap,
    output logic [XLEN-1:0] trapPC,
`endif
    output logic [2:0]      state_dbg
);

    // Handshakes: a request transfers when imemReq && imemReady; decode takes the
    // word when instValid && instReady. Valid never drops without a transfer except
    // on redirect/halt, and data is held stable while valid waits for ready.

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    fetch_state_t    state, state_nx;
    logic [XLEN-1:0] pc;
    logic            kill, halt_pend;
    logic [31:0]     inst_out_q;
    logic [XLEN-1:0] inst_pc_q;

    logic            sel_redirect, sel_halt;
    logic [XLEN-1:0] sel_target, sel_halt_pc;
    logic            active, do_redirect, do_halt, kill_eff, halt_pend_eff;
    logic [XLEN-1:0] redir_pc;

    pc_target_sel #(.XLEN(XLEN)) u_target_sel (
        .resolveValid (resolveValid),
        .JumpReg      (JumpReg),
        .Cnd          (Cnd),
        .Jump         (Jump),
        .Halt         (Halt),
        .resolvePC    (resolvePC),
        .imm          (imm),
        .aluResult    (aluResult),
        .redirect     (sel_redirect),
        .halt         (sel_halt),
        .target       (sel_target),
        .halt_pc      (sel_halt_pc)
    );

    assign active = (state == REQ) || (state == RESP) || (state == HOLD);

`ifdef MISALIGN_TRAP_EN
    logic misalign, do_trap;
    assign misalign    = sel_redirect && (sel_target[1:0] != 2'b00);
    assign do_trap     = active && misalign;
    assign do_redirect = active && sel_redirect && !misalign;
    // A misaligned target is turned into a halt that leaves pc untouched.
    assign do_halt     = active && (sel_halt || misalign);
    assign redir_pc    = sel_target;
`else
    assign do_redirect = active && sel_redirect;
    assign do_halt     = active && sel_halt;
    assign redir_pc    = sel_target & ALIGN_MASK;
`endif

    // A resolve landing while a request is in flight poisons its response.
    assign kill_eff      = kill || do_redirect || do_halt;
    assign halt_pend_eff = halt_pend || do_halt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:   state_nx = REQ;
            REQ: begin
                if (imemReady)    state_nx = RESP;
                else if (do_halt) state_nx = HALTED;
            end
            RESP: begin
                if (imemValid) begin
                    if (kill_eff) state_nx = halt_pend_eff ? HALTED : REQ;
                    else          state_nx = HOLD;
                end
            end
            HOLD: begin
                if (do_redirect)    state_nx = REQ;
                else if (do_halt)   state_nx = HALTED;
                else if (instReady) state_nx = REQ;
            end
            HALTED: if (resume) state_nx = REQ;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_VECTOR;
            kill       <= 1'b0;
            halt_pend  <= 1'b0;
            inst_out_q <= '0;
            inst_pc_q  <= '0;
        end else begin
            if (do_redirect)                  pc <= redir_pc;
            else if (active && sel_halt)      pc <= sel_halt_pc;
            else if (state == HOLD && instReady) pc <= pc + XLEN'(INST_STEP);

            if (state == REQ) begin
                kill      <= imemReady && (do_redirect || do_halt);
                halt_pend <= imemReady && do_halt;
            end else if (state == RESP) begin
                kill      <= imemValid ? 1'b0 : kill_eff;
                halt_pend <= imemValid ? 1'b0 : halt_pend_eff;
            end

            if (state == RESP && imemValid && !kill_eff) begin
                inst_out_q <= imemRdata;
                inst_pc_q  <= pc;
            end
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap   <= 1'b0;
            trapPC <= '0;
        end else if (do_trap) begin
            trap   <= 1'b1;
            trapPC <= resolvePC;
        end else if (state == HALTED && resume) begin
            trap   <= 1'b0;
        end
    end
`endif

    always_comb begin
        imemReq   = (state == REQ);
        imemAddr  = pc;
        instValid = (state == HOLD);
        instOut   = inst_out_q;
        instPC    = inst_pc_q;
        halted    = (state == HALTED);
        state_dbg = state;
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a latency-programmable memory responder
// and a delivered-instruction scoreboard checked every cycle.
module tb_pc_fetch_ctrl;
    import pc_fetch_pkg::*;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            imemReq;
    logic [XLEN-1:0] imemAddr;
    logic            imemReady;
    logic            imemValid;
    logic [31:0]     imemRdata;
    logic            instValid;
    logic            instReady;
    logic [31:0]     instOut;
    logic [XLEN-1:0] instPC;
    logic            resolveValid;
    logic [XLEN-1:0] resolvePC;
    logic            Cnd, Jump, JumpReg, Halt;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] aluResult;
    logic            halted;
    logic            resume;
    logic [2:0]      state_dbg;
`ifdef MISALIGN_TRAP_EN
    logic            trap;
    logic [XLEN-1:0] trapPC;
`endif

    int checks = 0;
    int errors = 0;
    int mem_lat = 0;
    logic [XLEN-1:0] exp_q[$];

    pc_fetch_ctrl #(.XLEN(XLEN), .RESET_VECTOR(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imemReq      (imemReq),
        .imemAddr     (imemAddr),
        .imemReady    (imemReady),
        .imemValid    (imemValid),
        .imemRdata    (imemRdata),
        .instValid    (instValid),
        .instReady    (instReady),
        .instOut      (instOut),
        .instPC       (instPC),
        .resolveValid (resolveValid),
        .resolvePC    (resolvePC),
        .Cnd          (Cnd),
        .Jump         (Jump),
        .JumpReg      (JumpReg),
        .Halt         (Halt),
        .imm          (imm),
        .aluResult    (aluResult),
        .halted       (halted),
        .resume       (resume),
`ifdef MISALIGN_TRAP_EN
        .trap         (trap),
        .trapPC       (trapPC),
`endif
        .state_dbg    (state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [XLEN-1:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_resolve();
        resolveValid = 1'b0;
        Cnd = 1'b0; Jump = 1'b0; JumpReg = 1'b0; Halt = 1'b0;
        resolvePC = '0; imm = '0; aluResult = '0;
    endtask

    // Memory responder: one outstanding request, answered mem_lat cycles after the
    // cycle following acceptance; shares rst_n so in-flight work is dropped.
    logic            busy;
    int              wait_cnt;
    logic [XLEN-1:0] req_addr;
    initial begin
        imemValid = 1'b0;
        imemRdata = '0;
        busy      = 1'b0;
        wait_cnt  = 0;
        req_addr  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) busy = 1'b0;
            else if (imemReq && imemReady && !busy) begin
                busy     = 1'b1;
                wait_cnt = mem_lat;
                req_addr = imemAddr;
            end
            @(posedge clk);
            #1;
            imemValid = 1'b0;
            if (busy && rst_n) begin
                if (wait_cnt == 0) begin
                    imemValid = 1'b1;
                    imemRdata = mem_word(req_addr);
                    busy      = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // Scoreboard: every decode transfer must match the next expected PC and carry
    // the memory word for that PC; halted and hold states never request.
    always @(negedge clk) begin
        if (rst_n) begin
            if (halted) begin
                check("halted_quiet", {30'd0, imemReq, instValid}, 32'd0);
                check("halted_state", {29'd0, state_dbg}, {29'd0, HALTED});
            end
            if (instValid) begin
                check("inst_word", instOut, mem_word(instPC));
                check("no_req_in_hold", {31'd0, imemReq}, 32'd0);
                if (instReady && !(resolveValid && (JumpReg || Cnd || Jump || Halt))) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_delivery", instPC, 32'hFFFF_FFFF);
                    end else begin
                        check("deliver_pc", instPC, exp_q.pop_front());
                    end
                end
            end
            if (imemReq) check("addr_align", {30'd0, imemAddr[1:0]}, 32'd0);
        end
    end

    initial begin
        rst_n = 1'b0;
        imemReady = 1'b1;
        instReady = 1'b1;
        resume = 1'b0;
        clear_resolve();
        repeat (3) tick();

        check("rst_imemReq", {31'd0, imemReq}, 32'd0);
        check("rst_instValid", {31'd0, instValid}, 32'd0);
        check("rst_instOut", instOut, 32'd0);
        check("rst_instPC", instPC, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_imemAddr", imemAddr, 32'd0);

        // Zero-wait sequential fetch: one instruction every third cycle.
        rst_n = 1'b1;
        check("idle_no_req", {31'd0, imemReq}, 32'd0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        for (int i = 1; i <= 9; i++) begin
            tick();
            check("cadence_valid", {31'd0, instValid}, (i % 3 == 0) ? 32'd1 : 32'd0);
            if (i % 3 == 1) begin
                check("cadence_req", {31'd0, imemReq}, 32'd1);
                check("cadence_addr", imemAddr, 32'(((i - 1) / 3) * 4));
            end
        end

        // Memory stalls the request: address held, nothing delivered.
        imemReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_req", {31'd0, imemReq}, 32'd1);
            check("stall_addr", imemAddr, 32'hC);
            check("stall_no_valid", {31'd0, instValid}, 32'd0);
        end
        imemReady = 1'b1;
        instReady = 1'b0;
        tick();
        tick();
        check("hold_valid", {31'd0, instValid}, 32'd1);
        check("hold_pc", instPC, 32'hC);
        tick();
        check("hold_stable_valid", {31'd0, instValid}, 32'd1);
        check("hold_stable_pc", instPC, 32'hC);

        // JALR with Cnd and instReady in HOLD: register jump wins, bit0 cleared.
        resolveValid = 1'b1; JumpReg = 1'b1; Cnd = 1'b1;
        aluResult = 32'h105; resolvePC = 32'h8; imm = 32'h40;
        instReady = 1'b1;
        tick();
        clear_resolve();
        check("jalr_valid_drop", {31'd0, instValid}, 32'd0);
        check("jalr_req", {31'd0, imemReq}, 32'd1);
        check("jalr_addr", imemAddr, 32'h104);
        exp_q.push_back(32'h104);
        tick();
        tick();
        check("jalr_deliver_pc", instPC, 32'h104);
        mem_lat = 2;

        // JAL while the response is outstanding: in-flight word is squashed.
        tick();
        check("jal_pre_addr", imemAddr, 32'h108);
        tick();
        resolveValid = 1'b1; Jump = 1'b1; resolvePC = 32'h10; imm = 32'h20;
        tick();
        clear_resolve();
        check("jal_wait_valid", {31'd0, instValid}, 32'd0);
        check("jal_wait_req", {31'd0, imemReq}, 32'd0);
        tick();
        check("jal_drop_valid", {31'd0, instValid}, 32'd0);
        mem_lat = 0;
        tick();
        check("jal_no_valid", {31'd0, instValid}, 32'd0);
        check("jal_req", {31'd0, imemReq}, 32'd1);
        check("jal_addr", imemAddr, 32'h30);
        exp_q.push_back(32'h30);
        tick();
        tick();
        check("jal_deliver_pc", instPC, 32'h30);
        imemReady = 1'b0;

        // Halt from an unaccepted REQ; resolves while halted are ignored.
        tick();
        check("pre_halt_addr", imemAddr, 32'h34);
        resolveValid = 1'b1; Halt = 1'b1; resolvePC = 32'h40;
        tick();
        clear_resolve();
        imemReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("halt_flag", {31'd0, halted}, 32'd1);
            check("halt_no_req", {31'd0, imemReq}, 32'd0);
            if (i == 2) begin
                resolveValid = 1'b1; Jump = 1'b1; resolvePC = 32'h0; imm = 32'h100;
            end
            if (i == 3) clear_resolve();
            if (i < 9) tick();
        end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check("resume_halted", {31'd0, halted}, 32'd0);
        check("resume_req", {31'd0, imemReq}, 32'd1);
        check("resume_addr", imemAddr, 32'h44);
        exp_q.push_back(32'h44);
        tick();
        tick();
        check("resume_deliver_pc", instPC, 32'h44);
        mem_lat = 3;

        // Reset asserted while waiting in RESP.
        tick();
        check("pre_rst_addr", imemAddr, 32'h48);
        tick();
        check("pre_rst_req", {31'd0, imemReq}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_imemReq", {31'd0, imemReq}, 32'd0);
        check("midrst_instValid", {31'd0, instValid}, 32'd0);
        check("midrst_instOut", instOut, 32'd0);
        check("midrst_instPC", instPC, 32'd0);
        check("midrst_imemAddr", imemAddr, 32'd0);
        check("midrst_halted", {31'd0, halted}, 32'd0);
        mem_lat = 0;
        tick();
        tick();
        rst_n = 1'b1;
        exp_q.push_back(32'h0);
        tick();
        check("post_rst_req", {31'd0, imemReq}, 32'd1);
        check("post_rst_addr", imemAddr, 32'h0);
        tick();
        tick();
        check("post_rst_valid", {31'd0, instValid}, 32'd1);
        check("post_rst_pc", instPC, 32'h0);
        tick();
        instReady = 1'b0;
        repeat (3) tick();
        check("queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
